sd_bitstream_modulator: RTL and testbench

Second-order sigma-delta modulator that turns multi-bit signed samples into a 1-bit density-modulated bitstream. It is the transmit-side counterpart of the SDFP bitstream controller. The controller's multi-bit output, or any upstream sample source, is accepted through a valid/ready handshake. Each accepted sample is held for OSR clocks and noise-shaped into bits that feed the P/Q bitstream inputs of downstream stages or the output DAC.

---
 rtl/sd_bitstream_modulator.sv | 136 +++++++++++++
 tb/tb_sd_bitstream_modulator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_bitstream_modulator.sv
// Second-order sigma-delta modulator: holds each accepted sample for OSR clocks and
// noise-shapes it into a 1-bit stream; one modulator update per clock, registered outputs.
module sd_bitstream_modulator #(
  parameter int IN_WIDTH  = 16,
  parameter int OSR       = 64,
  parameter int ACC_WIDTH = IN_WIDTH + 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                bit_out,
  output logic                bit_valid,
  output logic                underrun
);

  localparam int EW = ACC_WIDTH + 2;
  localparam logic signed [EW-1:0] FS_X =
    {{(EW-IN_WIDTH){1'b0}}, 1'b1, {(IN_WIDTH-1){1'b0}}};
  localparam logic signed [EW-1:0] ACC_MAX_X = {3'b000, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] ACC_MIN_X = {3'b111, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(OSR - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                       state_q, state_d;
  logic signed [IN_WIDTH-1:0]   hold_q, hold_d;
  logic signed [ACC_WIDTH-1:0]  i1_q, i1_d, i2_q, i2_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic                         bit_out_q, bit_out_d;
  logic                         bit_valid_q, bit_valid_d;
  logic                         underrun_q, underrun_d;

  logic                         at_last;
  logic                         accept;
  logic                         dec;
  logic signed [EW-1:0]         hold_x, fb_x, i1_x, i1_n_x, i2_x;
  logic signed [EW-1:0]         i1_sum, i2_sum;
  logic signed [ACC_WIDTH-1:0]  i1_n;

  function automatic logic signed [ACC_WIDTH-1:0] sat(input logic signed [EW-1:0] v);
    if (v > ACC_MAX_X)      sat = ACC_MAX_X[ACC_WIDTH-1:0];
    else if (v < ACC_MIN_X) sat = ACC_MIN_X[ACC_WIDTH-1:0];
    else                    sat = v[ACC_WIDTH-1:0];
  endfunction

  assign at_last = (cnt_q == CNT_LAST);
  assign accept  = in_valid & in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: RUN is left only through reset
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && accept) state_d = RUN;
  end

  // Output logic
  always_comb begin
    in_ready = 1'b0;
    if (reset) in_ready = (state_q == IDLE) || at_last;
  end

  // Loop filter: i2 sees the freshly updated i1 (delay-free second stage)
  always_comb begin
    dec    = ~i2_q[ACC_WIDTH-1];
    hold_x = {{(EW-IN_WIDTH){hold_q[IN_WIDTH-1]}}, hold_q};
    fb_x   = dec ? FS_X : -FS_X;
    i1_x   = {{2{i1_q[ACC_WIDTH-1]}}, i1_q};
    i2_x   = {{2{i2_q[ACC_WIDTH-1]}}, i2_q};
    i1_sum = i1_x + hold_x - fb_x;
    i1_n   = sat(i1_sum);
    i1_n_x = {{2{i1_n[ACC_WIDTH-1]}}, i1_n};
    i2_sum = i2_x + i1_n_x - fb_x;
  end

  always_comb begin
    hold_d      = hold_q;
    i1_d        = i1_q;
    i2_d        = i2_q;
    cnt_d       = cnt_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    underrun_d  = 1'b0;
    if (state_q == IDLE) begin
      if (accept) begin
        hold_d = in_data;
        cnt_d  = '0;
      end
    end else begin
      bit_out_d   = dec;
      bit_valid_d = 1'b1;
      i1_d        = i1_n;
      i2_d        = sat(i2_sum);
      // The boundary update above still uses the old sample; a new one lands next cycle
      if (at_last) begin
        cnt_d = '0;
        if (accept) hold_d = in_data;
        else        underrun_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q      <= '0;
      i1_q        <= '0;
      i2_q        <= '0;
      cnt_q       <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      cnt_q       <= cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_sd_bitstream_modulator.sv
// Bench for sd_bitstream_modulator: directed vector table, scripted scenarios and random
// traffic, all checked cycle by cycle against an integer reference model of the modulator.
module tb_sd_bitstream_modulator;

  localparam int  OSR = 64;
  localparam longint FS = 32768;
  localparam longint AMAX = (longint'(1) << 19) - 1;
  localparam longint AMIN = -(longint'(1) << 19);

  logic        clk;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        bit_out;
  logic        bit_valid;
  logic        underrun;

  sd_bitstream_modulator #(.IN_WIDTH(16), .OSR(OSR), .ACC_WIDTH(20), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bit_out(bit_out), .bit_valid(bit_valid), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: sample slot position, held value, two integrators in plain integers
  bit     m_run;
  int     m_pos;
  longint m_hold, m_i1, m_i2;
  bit     m_bo, m_bv, m_uf;
  bit     acc_last;

  task automatic check(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic longint clamp(input longint v);
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return v;
  endfunction

  function automatic bit m_rdy(input bit r);
    return r && (!m_run || m_pos == OSR - 1);
  endfunction

  task automatic model_step(input bit r, input bit v, input int d);
    logic signed [15:0] s;
    bit a;
    longint fb;
    s = d[15:0];
    a = v && m_rdy(r);
    if (!r) begin
      m_run = 0; m_pos = 0; m_hold = 0; m_i1 = 0; m_i2 = 0;
      m_bo = 0; m_bv = 0; m_uf = 0;
    end else if (!m_run) begin
      m_bv = 0; m_uf = 0;
      if (a) begin m_hold = s; m_pos = 0; m_run = 1; end
    end else begin
      m_bo = (m_i2 >= 0);
      m_bv = 1;
      fb   = m_bo ? FS : -FS;
      m_i1 = clamp(m_i1 + m_hold - fb);
      m_i2 = clamp(m_i2 + m_i1 - fb);
      m_uf = 0;
      if (m_pos == OSR - 1) begin
        m_pos = 0;
        if (a) m_hold = s;
        else   m_uf = 1;
      end else begin
        m_pos++;
      end
    end
  endtask

  // One clock: drive at negedge, compare just after, then advance the model
  task automatic cycle(input bit r, input bit v, input int d, input bit chk);
    bit er;
    @(negedge clk);
    reset = r; in_valid = v; in_data = d[15:0];
    #1;
    er = m_rdy(r);
    if (chk) begin
      check("in_ready", in_ready, er);
      check("bit_valid", bit_valid, m_bv);
      check("bit_out", bit_out, m_bo);
      check("underrun", underrun, m_uf);
    end
    acc_last = v && er;
    model_step(r, v, d);
  endtask

  task automatic reset_seq();
    cycle(0, 1, $urandom, 1);
    cycle(0, 0, $urandom, 1);
  endtask

  typedef struct {
    bit          rst;
    bit          vld;
    logic [15:0] dat;
    bit          rdy;
    bit          bv;
    bit          bo;
    bit          uf;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int acc, bits, ones, ufs, gaps, rdys, started;
    logic [3:0] pat;

    // reset-held rows, accept of 0, then the 1,0,0,1 zero-input pattern twice
    tbl[0]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 16'h7777, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};

    reset = 1'b0; in_valid = 1'b0; in_data = '0;
    cycle(0, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      reset = tbl[i].rst; in_valid = tbl[i].vld; in_data = tbl[i].dat;
      #1;
      check($sformatf("tbl%0d_rdy", i), in_ready, tbl[i].rdy);
      check($sformatf("tbl%0d_bv", i), bit_valid, tbl[i].bv);
      check($sformatf("tbl%0d_bo", i), bit_out, tbl[i].bo);
      check($sformatf("tbl%0d_uf", i), underrun, tbl[i].uf);
      model_step(tbl[i].rst, tbl[i].vld, int'(tbl[i].dat));
    end

    // 16 back-to-back samples of +FS/2
    reset_seq();
    acc = 0; bits = 0; ones = 0; ufs = 0; gaps = 0;
    for (int c = 0; c < 1200 && bits < 1024; c++) begin
      cycle(1, acc < 16, 16384, 1);
      if (acc_last) acc++;
      if (bits > 0 && bit_valid !== 1'b1) gaps++;
      if (bit_valid === 1'b1) begin
        bits++;
        if (bit_out === 1'b1) ones++;
      end
      if (underrun === 1'b1 && bits < 1024) ufs++;
    end
    check_int("half_bits", bits, 1024, 1024);
    check_int("half_ones", ones, 766, 770);
    check_int("half_underrun", ufs, 0, 0);
    check_int("half_gaps", gaps, 0, 0);

    // single sample 1000, then starvation
    reset_seq();
    cycle(1, 1, 1000, 1);
    ufs = 0; rdys = 0; gaps = 0; started = 0;
    for (int c = 0; c < 300; c++) begin
      cycle(1, 0, $urandom, 1);
      if (in_ready === 1'b1) rdys++;
      if (underrun === 1'b1) ufs++;
      if (started != 0 && bit_valid !== 1'b1) gaps++;
      if (bit_valid === 1'b1) started = 1;
    end
    check_int("starve_underruns", ufs, 4, 4);
    check_int("starve_ready", rdys, 4, 4);
    check_int("starve_gaps", gaps, 0, 0);

    // negative full scale for 4096 bits: integrators must clamp, not wrap
    reset_seq();
    acc = 0; bits = 0; ones = 0;
    for (int c = 0; c < 4300 && bits < 4096; c++) begin
      cycle(1, acc < 64, 32'hFFFF8000, 1);
      if (acc_last) acc++;
      if (bit_valid === 1'b1) begin
        bits++;
        if (bit_out === 1'b1) ones++;
      end
    end
    check_int("negfs_bits", bits, 4096, 4096);
    check_int("negfs_ones", ones, 0, 8);

    // reset in the middle of a sample, then a clean restart with zero input
    reset_seq();
    cycle(1, 1, $urandom, 1);
    for (int c = 0; c < 17; c++) cycle(1, 0, 0, 1);
    cycle(0, 1, $urandom, 1);
    cycle(1, 1, 0, 1);
    check("midrst_bv", bit_valid, 1'b0);
    check("midrst_rdy", in_ready, 1'b1);
    cycle(1, 0, 0, 1);
    for (int c = 0; c < 4; c++) begin
      cycle(1, 0, 0, 1);
      pat[3-c] = bit_out;
    end
    total++;
    if (pat !== 4'b1001) begin
      bad++;
      $display("FAIL restart_pattern: got %b expected 1001", pat);
    end

    // random traffic with occasional resets
    reset_seq();
    for (int c = 0; c < 3000; c++)
      cycle($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0, $urandom, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
